// File: rtl/dcache_controller_if.sv
// CPU, memory-bus and SRAM signal bundle for the data cache controller.
// The master modport is the controller side; slave is the CPU/memory/SRAM side.
interface dcache_controller_if #(
  parameter int LINE_W  = 256,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 23
);
  logic              cpu_req_i;
  logic              cpu_write_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  logic              sram_enable_o;
  logic              sram_write_o;
  logic [INDEX_W-1:0] sram_addr_o;
  logic [TAG_W+1:0]  sram_tag_o;
  logic [LINE_W-1:0] sram_data_o;
  logic [TAG_W+1:0]  sram_tag_i;
  logic [LINE_W-1:0] sram_data_i;
  logic              sram_hit_i;

  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i,
    output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    input  sram_tag_i, sram_data_i, sram_hit_i
  );

  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i,
    input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    output sram_tag_i, sram_data_i, sram_hit_i
  );
endinterface

// File: rtl/dcache_controller.sv
// Data cache sequencer: hit/miss detection, dirty-victim write-back, line refill
// and store-word merge between the CPU port, cache SRAM and line-wide memory.
module dcache_controller #(
  parameter int LINE_W  = 256,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 23
) (
  input logic clk_i,
  input logic rst_i,
  dcache_controller_if.master bus
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSEL_W = $clog2(LINE_W / 32);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] MISS        = 3'd1;
  localparam logic [2:0] WRITEBACK   = 3'd2;
  localparam logic [2:0] REFILL      = 3'd3;
  localparam logic [2:0] REFILL_DONE = 3'd4;

  logic [2:0]        r_state;
  logic              r_mem_enable;
  logic              r_mem_write;
  logic [31:0]       r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [WSEL_W-1:0]  w_word;
  logic [TAG_W-1:0]   w_vic_tag;
  logic               w_vic_dirty;
  logic               w_req;
  logic               w_idle_hit;
  logic               w_refill_wr;
  logic [LINE_W-1:0]  w_merged;
  logic               w_unused;

  assign w_req       = bus.cpu_req_i;
  assign w_index     = bus.cpu_addr_i[OFF_W +: INDEX_W];
  assign w_tag       = bus.cpu_addr_i[31 -: TAG_W];
  assign w_word      = bus.cpu_addr_i[OFF_W-1:2];
  assign w_vic_tag   = bus.sram_tag_i[TAG_W-1:0];
  assign w_vic_dirty = bus.sram_tag_i[TAG_W+1] & bus.sram_tag_i[TAG_W];
  assign w_idle_hit  = (r_state == IDLE) & bus.sram_hit_i;
  assign w_refill_wr = (r_state == REFILL) & bus.mem_ack_i;
  assign w_unused    = ^bus.cpu_addr_i[1:0];

  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  assign bus.cpu_stall_o = w_req & ~w_idle_hit;
  assign bus.cpu_data_o  = bus.sram_data_i[32*w_word +: 32] & {32{w_req}};
  assign bus.sram_addr_o = w_index;

  always_comb begin
    w_merged = bus.sram_data_i;
    w_merged[32*w_word +: 32] = bus.cpu_data_i;
  end

  // The refill write completes the sequence even if the CPU has dropped its request.
  always_comb begin
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    if (r_state == IDLE || r_state == MISS) bus.sram_enable_o = w_req;
    if (w_req && w_idle_hit && bus.cpu_write_i) begin
      bus.sram_write_o = 1'b1;
      bus.sram_tag_o   = {2'b11, w_tag};
      bus.sram_data_o  = w_merged;
    end
    if (w_refill_wr) begin
      bus.sram_enable_o = 1'b1;
      bus.sram_write_o  = 1'b1;
      bus.sram_tag_o    = {2'b10, w_tag};
      bus.sram_data_o   = bus.mem_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req && !bus.sram_hit_i) r_state <= MISS;
        MISS: begin
          r_mem_enable <= 1'b1;
          if (w_vic_dirty) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= {w_vic_tag, w_index, {OFF_W{1'b0}}};
            r_mem_data  <= bus.sram_data_i;
            r_state     <= WRITEBACK;
          end else begin
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_tag, w_index, {OFF_W{1'b0}}};
            r_state     <= REFILL;
          end
        end
        WRITEBACK: if (bus.mem_ack_i) begin
          r_mem_write <= 1'b0;
          r_mem_addr  <= {w_tag, w_index, {OFF_W{1'b0}}};
          r_state     <= REFILL;
        end
        REFILL: if (bus.mem_ack_i) begin
          r_mem_enable <= 1'b0;
          r_state      <= REFILL_DONE;
        end
        REFILL_DONE: r_state <= IDLE;
        default:     r_state <= IDLE;
      endcase
    end
  end
endmodule
